// File: rtl/nano_pkg.sv
// nano_pkg: shared encodings for the nanoprocessor sequencer.
//   state_t  - sequencer state (IF, AF, EX, HALT), also exported on the debug port
//   alu_op_t - ALU operation select driven to the datapath
//   OP_*     - opcode byte values
//   dec_t    - decoded opcode bundle handed from nano_ctrl_decode to nano_ctrl
package nano_pkg;

  typedef enum logic [1:0] {
    ST_IF   = 2'd0,
    ST_AF   = 2'd1,
    ST_EX   = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_B = 3'd5
  } alu_op_t;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;
  localparam logic [7:0] OP_OR  = 8'h04;
  localparam logic [7:0] OP_XOR = 8'h05;
  localparam logic [7:0] OP_LDA = 8'h06;
  localparam logic [7:0] OP_STA = 8'h07;
  localparam logic [7:0] OP_JMP = 8'h08;
  localparam logic [7:0] OP_JZ  = 8'h09;
  localparam logic [7:0] OP_JC  = 8'h0A;
  localparam logic [7:0] OP_HLT = 8'h0B;

  typedef struct packed {
    alu_op_t alu_op;
    logic    is_alu;   // ADD..XOR and LDA: ACC/flags load from memory operand
    logic    is_sta;
    logic    is_jmp;
    logic    is_jz;
    logic    is_jc;
    logic    is_hlt;
  } dec_t;

endpackage

// File: rtl/nano_ctrl_decode.sv
// nano_ctrl_decode: pure combinational opcode decoder.
//   opcode - instruction register contents
//   dec    - alu_op plus one-hot-ish instruction class flags
// Unknown opcodes decode to all-zero flags, so they execute as NOP.
module nano_ctrl_decode
  import nano_pkg::*;
(
  input  logic [7:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_PASS_B;
    case (opcode)
      OP_ADD: begin dec.is_alu = 1'b1; dec.alu_op = ALU_ADD; end
      OP_SUB: begin dec.is_alu = 1'b1; dec.alu_op = ALU_SUB; end
      OP_AND: begin dec.is_alu = 1'b1; dec.alu_op = ALU_AND; end
      OP_OR:  begin dec.is_alu = 1'b1; dec.alu_op = ALU_OR;  end
      OP_XOR: begin dec.is_alu = 1'b1; dec.alu_op = ALU_XOR; end
      OP_LDA: begin dec.is_alu = 1'b1; dec.alu_op = ALU_PASS_B; end
      OP_STA: dec.is_sta = 1'b1;
      OP_JMP: dec.is_jmp = 1'b1;
      OP_JZ:  dec.is_jz  = 1'b1;
      OP_JC:  dec.is_jc  = 1'b1;
      OP_HLT: dec.is_hlt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/nano_ctrl.sv
// nano_ctrl: three-cycle fetch/operand/execute sequencer for the nanoprocessor.
//   clk, reset_n        - clock, async active-low reset
//   data_in             - memory read data (combinational read)
//   Z, C                - registered flags from the datapath
//   inc_PC, load_PC     - PC increment / load-from-AD strobes
//   load_AD, addr_sel   - operand register load, memory address source (0=PC, 1=AD)
//   load_ACC, load_flags, alu_op - accumulator/flag load and ALU select
//   mem_we              - store accumulator at AD
//   halted, state       - HALT indication and debug state
// All outputs are combinational from (state, IR, Z, C).
module nano_ctrl
  import nano_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       Z,
  input  logic       C,
  output logic       inc_PC,
  output logic       load_PC,
  output logic       load_AD,
  output logic       addr_sel,
  output logic       load_ACC,
  output logic       load_flags,
  output logic [2:0] alu_op,
  output logic       mem_we,
  output logic       halted,
  output logic [1:0] state
);

  state_t     state_q, state_d;
  logic [7:0] ir_q;
  dec_t       dec;
  alu_op_t    aop;

  nano_ctrl_decode u_dec (
    .opcode (ir_q),
    .dec    (dec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IF;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IF) ir_q <= data_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    inc_PC     = 1'b0;
    load_PC    = 1'b0;
    load_AD    = 1'b0;
    addr_sel   = 1'b0;
    load_ACC   = 1'b0;
    load_flags = 1'b0;
    mem_we     = 1'b0;
    aop        = ALU_PASS_B;
    unique case (state_q)
      ST_IF: begin
        inc_PC  = 1'b1;
        state_d = ST_AF;
      end
      ST_AF: begin
        inc_PC  = 1'b1;
        load_AD = 1'b1;
        state_d = ST_EX;
      end
      ST_EX: begin
        state_d = dec.is_hlt ? ST_HALT : ST_IF;
        if (dec.is_alu) begin
          addr_sel   = 1'b1;
          aop        = dec.alu_op;
          load_ACC   = 1'b1;
          load_flags = 1'b1;
        end
        if (dec.is_sta) begin
          addr_sel = 1'b1;
          mem_we   = 1'b1;
        end
        // Flags are registered in the datapath, so Z/C here already reflect
        // the previous ALU instruction's EX edge.
        load_PC = dec.is_jmp | (dec.is_jz & Z) | (dec.is_jc & C);
      end
      ST_HALT: ;
      default: state_d = ST_IF;
    endcase
  end

  assign alu_op = aop;
  assign halted = (state_q == ST_HALT);
  assign state  = state_q;

endmodule
